// File: rtl/ethstream_tx_arbiter.sv
// -----------------------------------------------------------------------------
// ethstream_tx_arbiter
//
// Packet-granular round-robin arbiter in front of the Ethernet streamer's UDP
// transmit stream. NUM_SRC byte-wide AXI-Stream sources each deliver packets
// already framed for the streamer (2-byte length header LSB first, payload,
// tlast on the final payload byte). A grant is held for a whole packet and
// only released after the tlast handshake, so headers and payloads of
// different sources never interleave. New packets are started only while
// stream_linked is high.
//
// Valid/ready: a byte moves on a rising clk edge when the granted source's
// s_axis_tvalid and m_axis_tready are both high; s_axis_tready of the granted
// source is m_axis_tready passed straight through, every other ready is 0,
// and nothing is buffered inside the block.
//
// Optional feature (compile-time macro ETHSTREAM_TX_ARB_STATS_EN):
//   defined   -> pkt_count holds one 16-bit wrapping completed-packet counter
//                per source, cleared only by aresetn.
//   undefined -> pkt_count is tied to zero and no counter flops exist.
//
// Ports:
//   clk            single clock
//   aresetn        asynchronous active-low reset
//   stream_linked  UDP destination established; gates new grants only
//   s_axis_tdata   source data, source i at [8*i +: 8]
//   s_axis_tvalid  per-source valid
//   s_axis_tlast   per-source last
//   s_axis_tready  per-source ready
//   m_axis_tdata   data to the streamer
//   m_axis_tvalid  valid to the streamer
//   m_axis_tlast   last to the streamer
//   m_axis_tready  ready from the streamer
//   grant_idx      index of the current or most recent grant
//   busy           high while a packet is being passed (FSM in PASS); this
//                  is the externally visible FSM state
//   pkt_count      per-source completed-packet counters, source i at [16*i +: 16]
//
// Parameters:
//   NUM_SRC   number of sources, legal range 2..8
//   SEL_BITS  width of grant_idx, 2**SEL_BITS must be >= NUM_SRC
// -----------------------------------------------------------------------------
module ethstream_tx_arbiter #(
   parameter int NUM_SRC  = 4,
   parameter int SEL_BITS = 3
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic                    stream_linked,
   input  logic [NUM_SRC*8-1:0]    s_axis_tdata,
   input  logic [NUM_SRC-1:0]      s_axis_tvalid,
   input  logic [NUM_SRC-1:0]      s_axis_tlast,
   output logic [NUM_SRC-1:0]      s_axis_tready,
   output logic [7:0]              m_axis_tdata,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic [SEL_BITS-1:0]     grant_idx,
   output logic                    busy,
   output logic [NUM_SRC*16-1:0]   pkt_count
);

   // FSM encoding
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PASS = 1'b1;

   // Reset value of last_grant: the highest index, so that the rotating scan
   // starts at source 0 after reset.
   localparam logic [SEL_BITS-1:0] LAST_GRANT_RST = SEL_BITS'(NUM_SRC - 1);

   logic [0:0]          state;
   logic [SEL_BITS-1:0] last_grant;

   // Signals of the currently granted source
   logic [7:0]          g_tdata;
   logic                g_tvalid;
   logic                g_tlast;
   logic [NUM_SRC-1:0]  g_onehot;

   logic                in_pass;
   logic                pkt_done;

   // Arbitration result
   logic                req_any;
   logic [SEL_BITS-1:0] pick_idx;

   assign in_pass = (state == ST_PASS);
   assign busy    = in_pass;

   // --------------------------------------------------------------------------
   // Granted-source selection. Compare against each legal index instead of
   // indexing with grant_idx directly, so grant_idx may be wider than needed
   // without out-of-range reads.
   // --------------------------------------------------------------------------
   always_comb begin
      g_tdata  = '0;
      g_tvalid = 1'b0;
      g_tlast  = 1'b0;
      g_onehot = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_idx == SEL_BITS'(i)) begin
            g_tdata     = s_axis_tdata[8*i +: 8];
            g_tvalid    = s_axis_tvalid[i];
            g_tlast     = s_axis_tlast[i];
            g_onehot[i] = 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Output path: purely combinational from the registered grant, forced to
   // zero outside PASS so that IDLE (and reset) present a quiet interface.
   // --------------------------------------------------------------------------
   assign m_axis_tdata  = in_pass ? g_tdata : 8'h00;
   assign m_axis_tvalid = in_pass & g_tvalid;
   assign m_axis_tlast  = in_pass & g_tlast;
   assign s_axis_tready = {NUM_SRC{in_pass & m_axis_tready}} & g_onehot;

   // Final byte of the packet is accepted by the streamer this cycle
   assign pkt_done = in_pass & g_tvalid & m_axis_tready & g_tlast;

   // --------------------------------------------------------------------------
   // Round-robin pick: scan last_grant+1, last_grant+2, ... modulo NUM_SRC and
   // take the first requester. Because last_grant itself is scanned last, a
   // source that just finished has the lowest priority in the next decision.
   // The inner loop compares the rotated candidate with constant indices so
   // every request bit is selected with a static index.
   // --------------------------------------------------------------------------
   always_comb begin
      int cand;
      cand     = 0;
      req_any  = 1'b0;
      pick_idx = last_grant;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = int'(last_grant) + k;
         if (cand >= NUM_SRC) begin
            cand = cand - NUM_SRC;
         end
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!req_any && (cand == i) && s_axis_tvalid[i]) begin
               req_any  = 1'b1;
               pick_idx = SEL_BITS'(i);
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // FSM. IDLE uses the current stream_linked value, so a link drop in the
   // decision cycle blocks the grant. Once in PASS the link is ignored and the
   // packet always finishes. Every packet is followed by at least one IDLE
   // cycle.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= ST_IDLE;
         grant_idx  <= '0;
         last_grant <= LAST_GRANT_RST;
      end else begin
         case (state)
            ST_IDLE: begin
               if (stream_linked && req_any) begin
                  grant_idx <= pick_idx;
                  state     <= ST_PASS;
               end
            end
            ST_PASS: begin
               if (pkt_done) begin
                  last_grant <= grant_idx;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Per-source completed-packet counters
   // --------------------------------------------------------------------------
`ifdef ETHSTREAM_TX_ARB_STATS_EN
   logic [15:0] cnt_q [NUM_SRC];

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            cnt_q[i] <= 16'h0000;
         end
      end else if (pkt_done) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            // 16-bit add wraps 0xFFFF -> 0x0000 naturally
            if (g_onehot[i]) begin
               cnt_q[i] <= cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      pkt_count = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         pkt_count[16*i +: 16] = cnt_q[i];
      end
   end
`else
   assign pkt_count = '0;
`endif

endmodule

// File: doc/ethstream_tx_arbiter.md
Name: ethstream_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single UDP transmit stream port of the Ethernet streamer between NUM_SRC byte-wide AXI-Stream sources.
- Each source packet is already framed for the streamer: a 2-byte length header (LSB first, then MSB), then the payload, with tlast on the final payload byte.
- The arbiter holds a grant for the whole packet and only re-arbitrates after the tlast handshake, so length headers and payloads are never interleaved.
- It sits between the firmware packet producers and the streamer's s_axis input, and starts new packets only while the stream is linked.

Parameters:
- NUM_SRC, 4: number of sources, legal range 2..8.
- SEL_BITS, 3: width of the grant index; must satisfy 2^SEL_BITS >= NUM_SRC.

Ports:
- clk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- stream_linked  in  1  high when a UDP destination is established; gates new grants only.
- s_axis_tdata  in  NUM_SRC*8  source data; source i occupies bits [8*i +: 8].
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source last.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  8  data to the streamer.
- m_axis_tvalid  out  1  valid to the streamer.
- m_axis_tlast  out  1  last to the streamer.
- m_axis_tready  in  1  ready from the streamer.
- grant_idx  out  SEL_BITS  index of the current or most recent grant.
- busy  out  1  high while in PASS.
- pkt_count  out  NUM_SRC*16  per-source completed-packet counters (optional feature).

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, grant_idx=0, last_grant=NUM_SRC-1 so source 0 wins first, busy=0, all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, pkt_count=0.
- States: IDLE, PASS.
- IDLE:
  - All s_axis_tready and m_axis_tvalid are low.
  - If stream_linked=1 and any s_axis_tvalid[i]=1: pick the first requesting index scanning last_grant+1, last_grant+2, ... modulo NUM_SRC. Register it into grant_idx and go to PASS on the next edge.
  - Arbitration latency: one cycle from request visible to the first byte offered on m_axis.
- PASS:
  - The output mux is purely combinational from the registered grant: m_axis_tdata=s_axis_tdata[grant], m_axis_tvalid=s_axis_tvalid[grant], m_axis_tlast=s_axis_tlast[grant].
  - s_axis_tready[grant]=m_axis_tready; all other readies are 0. No data is buffered inside the block; zero added latency.
  - On s_axis_tvalid[grant] & m_axis_tready & s_axis_tlast[grant]: last_grant<=grant, go to IDLE.
  - busy=1 throughout PASS.
- Back-to-back: at least one IDLE cycle between packets, i.e. one bubble cycle per packet.
- Fairness: with all sources continuously requesting, grants go 0,1,2,3,0,... Sources that are not requesting are skipped without a wasted cycle.
- A grant is never revoked mid-packet. A stalled source (tvalid low) or a stalled sink holds PASS indefinitely.
- stream_linked falling during PASS: the packet completes normally. No new grant is issued until stream_linked=1.
- stream_linked falling in the same cycle as the arbitration decision: the IDLE check uses the current-cycle value, so no grant is issued.
- Simultaneous tlast handshake and a new request from the same source: that source has lowest priority in the next IDLE cycle.
- Packet size is unrestricted. Length-header correctness is the source's responsibility; the arbiter does not inspect data.
- aresetn asserted mid-packet: all outputs and state return to reset values immediately. The partial packet is abandoned; the streamer is reset via the same link/reset path.

Optional Feature:
- Macro: ETHSTREAM_TX_ARB_STATS_EN.
- Defined: pkt_count[16*i +: 16] increments by 1 on each tlast handshake granted to source i, and wraps 0xFFFF->0x0000. Cleared only by aresetn.
- Undefined: the pkt_count port exists but is tied to all zeros, and no counter flops are synthesized.

Test Plan:
- Single source: source 2 sends a 5-byte packet (0x03,0x00,0xA1,0xA2,0xA3); m_axis_tready=1, stream_linked=1 -> m_axis carries exactly those 5 bytes; tlast only on 0xA3; grant_idx=2; busy drops the cycle after tlast; other readies stay 0.
- Round-robin: all 4 sources continuously offer 4-byte packets -> grant order 0,1,2,3,0,1; exactly one IDLE cycle between packets; no byte interleaving.
- Backpressure: during the packet from source 1, toggle m_axis_tready 1,0,0,1,... -> s_axis_tready[1] mirrors it every cycle; no bytes are lost or duplicated; the bench scoreboard matches.
- Link gating: stream_linked=0 with source 0 valid -> no grant for 20 cycles. Raise stream_linked -> grant to 0 after 1 cycle. Drop stream_linked mid-packet -> the packet still completes; no further grant.
- Reset mid-packet: assert aresetn=0 on the 3rd byte of source 3's packet -> all outputs are 0 asynchronously. After release, source 0 wins first if requesting.
- Stats (macro defined): send 3 packets from source 1 and 1 from source 0 -> pkt_count reads {0,0,3,1} from source 3 down to source 0. Preload via 65536 packets on source 0 -> that counter wraps to 0.
